// File: rtl/operand_issue_if.sv
// Decode-side and EX-side handshake bundles of the operand issue stage.
interface operand_issue_if #(
    parameter int XLEN = 64,
    parameter int OP_W = 8
);
    // Decode -> issue
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_op;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [4:0]      in_rs1_index;
    logic [4:0]      in_rs2_index;
    logic            in_rs1_en;
    logic            in_rs2_en;
    logic [4:0]      in_rd_index;
    logic            in_rd_en;
    logic            in_is_load;

    // Issue -> EX
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] out_op;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [4:0]      out_rd_index;
    logic            out_rd_en;
    logic            out_is_load;

    // Environment side: drives decode, consumes EX.
    modport master (
        output in_valid, in_op, in_pc, in_imm, in_rs1_index, in_rs2_index,
               in_rs1_en, in_rs2_en, in_rd_index, in_rd_en, in_is_load,
        input  in_ready,
        input  out_valid, out_op, out_pc, out_imm, out_rs1_data, out_rs2_data,
               out_rd_index, out_rd_en, out_is_load,
        output out_ready
    );

    // Issue stage side.
    modport slave (
        input  in_valid, in_op, in_pc, in_imm, in_rs1_index, in_rs2_index,
               in_rs1_en, in_rs2_en, in_rd_index, in_rd_en, in_is_load,
        output in_ready,
        output out_valid, out_op, out_pc, out_imm, out_rs1_data, out_rs2_data,
               out_rd_index, out_rd_en, out_is_load,
        input  out_ready
    );
endinterface

// File: rtl/operand_issue.sv
// Operand fetch / issue stage: register-file read, EX/MEM/WB bypass,
// RAW hazard hold and an EX-bound valid/ready pipeline register.
module operand_issue #(
    parameter int XLEN  = 64,
    parameter int OP_W  = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    operand_issue_if.slave   io,

    output logic [4:0]       rf_rs1_index,
    output logic [4:0]       rf_rs2_index,
    output logic             rf_rs1_en,
    output logic             rf_rs2_en,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,

    input  logic             fwd_ex_valid,
    input  logic [4:0]       fwd_ex_rd_index,
    input  logic [XLEN-1:0]  fwd_ex_data,
    input  logic             fwd_ex_pending,
    input  logic             fwd_mem_valid,
    input  logic [4:0]       fwd_mem_rd_index,
    input  logic [XLEN-1:0]  fwd_mem_data,
    input  logic             fwd_wb_valid,
    input  logic [4:0]       fwd_wb_rd_index,
    input  logic [XLEN-1:0]  fwd_wb_data,

    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    // EX-bound register
    logic            out_valid_q,    out_valid_d;
    logic [OP_W-1:0] out_op_q,       out_op_d;
    logic [XLEN-1:0] out_pc_q,       out_pc_d;
    logic [XLEN-1:0] out_imm_q,      out_imm_d;
    logic [XLEN-1:0] out_rs1_data_q, out_rs1_data_d;
    logic [XLEN-1:0] out_rs2_data_q, out_rs2_data_d;
    logic [4:0]      out_rd_index_q, out_rd_index_d;
    logic            out_rd_en_q,    out_rd_en_d;
    logic            out_is_load_q,  out_is_load_d;
    logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;

    // Per-source views, element 0 = rs1, element 1 = rs2
    logic [4:0]      src_idx [2];
    logic            src_en  [2];
    logic [XLEN-1:0] src_rf  [2];
    logic [XLEN-1:0] src_val [2];
    logic [1:0]      src_haz;

    logic hazard;
    logic in_ready;
    logic accept;

    assign rf_rs1_index = io.in_rs1_index;
    assign rf_rs2_index = io.in_rs2_index;
    assign rf_rs1_en    = io.in_rs1_en;
    assign rf_rs2_en    = io.in_rs2_en;

    assign src_idx[0] = io.in_rs1_index;
    assign src_idx[1] = io.in_rs2_index;
    assign src_en[0]  = io.in_rs1_en;
    assign src_en[1]  = io.in_rs2_en;
    assign src_rf[0]  = rf_rs1_data;
    assign src_rf[1]  = rf_rs2_data;

    // Bypass select and hazard detect per source. Because the source index
    // is known to be nonzero inside the match terms, a forwarding slot with
    // rd_index 0 can never match. The register file returns the pre-write
    // value during a WB write, so WB must be bypassed explicitly.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_val[s] = '0;
            src_haz[s] = 1'b0;
            if (src_en[s] && (src_idx[s] != 5'd0)) begin
                if (fwd_ex_valid && !fwd_ex_pending && (fwd_ex_rd_index == src_idx[s]))
                    src_val[s] = fwd_ex_data;
                else if (fwd_mem_valid && (fwd_mem_rd_index == src_idx[s]))
                    src_val[s] = fwd_mem_data;
                else if (fwd_wb_valid && (fwd_wb_rd_index == src_idx[s]))
                    src_val[s] = fwd_wb_data;
                else
                    src_val[s] = src_rf[s];

                // The occupant of the EX-bound register has not computed its
                // result yet, even if EX takes it this very cycle.
                src_haz[s] = (out_valid_q && out_rd_en_q && (out_rd_index_q == src_idx[s])) ||
                             (fwd_ex_valid && fwd_ex_pending && (fwd_ex_rd_index == src_idx[s]));
            end
        end
    end

    assign hazard      = |src_haz;
    assign in_ready    = !flush && !hazard && (!out_valid_q || io.out_ready);
    assign accept      = io.in_valid && in_ready;
    assign io.in_ready = in_ready;

    // Next-state of the EX-bound register and the stall counter
    always_comb begin
        out_valid_d    = out_valid_q;
        out_op_d       = out_op_q;
        out_pc_d       = out_pc_q;
        out_imm_d      = out_imm_q;
        out_rs1_data_d = out_rs1_data_q;
        out_rs2_data_d = out_rs2_data_q;
        out_rd_index_d = out_rd_index_q;
        out_rd_en_d    = out_rd_en_q;
        out_is_load_d  = out_is_load_q;
        stall_cnt_d    = stall_cnt_q;

        if (io.in_valid && hazard && !flush)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (!out_valid_q || io.out_ready) begin
            out_valid_d = accept;
            if (accept) begin
                out_op_d       = io.in_op;
                out_pc_d       = io.in_pc;
                out_imm_d      = io.in_imm;
                out_rs1_data_d = src_val[0];
                out_rs2_data_d = src_val[1];
                out_rd_index_d = io.in_rd_index;
                out_rd_en_d    = io.in_rd_en;
                out_is_load_d  = io.in_is_load;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_op_q       <= '0;
            out_pc_q       <= '0;
            out_imm_q      <= '0;
            out_rs1_data_q <= '0;
            out_rs2_data_q <= '0;
            out_rd_index_q <= '0;
            out_rd_en_q    <= 1'b0;
            out_is_load_q  <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_op_q       <= out_op_d;
            out_pc_q       <= out_pc_d;
            out_imm_q      <= out_imm_d;
            out_rs1_data_q <= out_rs1_data_d;
            out_rs2_data_q <= out_rs2_data_d;
            out_rd_index_q <= out_rd_index_d;
            out_rd_en_q    <= out_rd_en_d;
            out_is_load_q  <= out_is_load_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign io.out_valid    = out_valid_q;
    assign io.out_op       = out_op_q;
    assign io.out_pc       = out_pc_q;
    assign io.out_imm      = out_imm_q;
    assign io.out_rs1_data = out_rs1_data_q;
    assign io.out_rs2_data = out_rs2_data_q;
    assign io.out_rd_index = out_rd_index_q;
    assign io.out_rd_en    = out_rd_en_q;
    assign io.out_is_load  = out_is_load_q;
    assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_operand_issue.sv
// Self-checking bench for operand_issue: directed test-plan sequences with
// literal expectations, then randomized traffic, all checked every cycle
// against a behavioural model of the issue stage.
module tb_operand_issue;
    localparam int XLEN  = 64;
    localparam int OP_W  = 8;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_issue_if #(.XLEN(XLEN), .OP_W(OP_W)) io ();

    logic [4:0]       rf_rs1_index, rf_rs2_index;
    logic             rf_rs1_en, rf_rs2_en;
    logic [XLEN-1:0]  rf_rs1_data, rf_rs2_data;
    logic             fwd_ex_valid, fwd_ex_pending;
    logic [4:0]       fwd_ex_rd_index;
    logic [XLEN-1:0]  fwd_ex_data;
    logic             fwd_mem_valid;
    logic [4:0]       fwd_mem_rd_index;
    logic [XLEN-1:0]  fwd_mem_data;
    logic             fwd_wb_valid;
    logic [4:0]       fwd_wb_rd_index;
    logic [XLEN-1:0]  fwd_wb_data;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    operand_issue #(.XLEN(XLEN), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .io               (io.slave),
        .rf_rs1_index     (rf_rs1_index),
        .rf_rs2_index     (rf_rs2_index),
        .rf_rs1_en        (rf_rs1_en),
        .rf_rs2_en        (rf_rs2_en),
        .rf_rs1_data      (rf_rs1_data),
        .rf_rs2_data      (rf_rs2_data),
        .fwd_ex_valid     (fwd_ex_valid),
        .fwd_ex_rd_index  (fwd_ex_rd_index),
        .fwd_ex_data      (fwd_ex_data),
        .fwd_ex_pending   (fwd_ex_pending),
        .fwd_mem_valid    (fwd_mem_valid),
        .fwd_mem_rd_index (fwd_mem_rd_index),
        .fwd_mem_data     (fwd_mem_data),
        .fwd_wb_valid     (fwd_wb_valid),
        .fwd_wb_rd_index  (fwd_wb_rd_index),
        .fwd_wb_data      (fwd_wb_data),
        .flush            (flush),
        .stall_cnt        (stall_cnt)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] pc, imm, a, b;
        logic [4:0]      rd;
        logic            rd_en, ld;
    } entry_t;

    bit          m_known = 0;
    bit          m_valid;
    entry_t      m_e;
    logic [CNT_W-1:0] m_stall;

    function automatic logic [XLEN-1:0] m_operand(input logic en, input logic [4:0] idx,
                                                  input logic [XLEN-1:0] rf);
        if (!en || idx == 0) return '0;
        if (fwd_ex_valid && fwd_ex_rd_index == idx && !fwd_ex_pending) return fwd_ex_data;
        if (fwd_mem_valid && fwd_mem_rd_index == idx) return fwd_mem_data;
        if (fwd_wb_valid && fwd_wb_rd_index == idx) return fwd_wb_data;
        return rf;
    endfunction

    // A source waits if the instruction ahead still owes it a value.
    function automatic bit m_waits(input logic en, input logic [4:0] idx);
        if (!en || idx == 0) return 0;
        if (m_valid && m_e.rd_en && m_e.rd == idx) return 1;
        if (fwd_ex_valid && fwd_ex_pending && fwd_ex_rd_index == idx) return 1;
        return 0;
    endfunction

    // Compare every cycle on the falling edge, then advance the model with
    // the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        bit haz, rdy;
        haz = m_waits(io.in_rs1_en, io.in_rs1_index) || m_waits(io.in_rs2_en, io.in_rs2_index);
        rdy = !flush && !haz && (!m_valid || io.out_ready);
        if (m_known) begin
            chk("out_valid", XLEN'(io.out_valid), XLEN'(m_valid));
            chk("out_op",    XLEN'(io.out_op), XLEN'(m_e.op));
            chk("out_pc",    io.out_pc, m_e.pc);
            chk("out_imm",   io.out_imm, m_e.imm);
            chk("out_rs1",   io.out_rs1_data, m_e.a);
            chk("out_rs2",   io.out_rs2_data, m_e.b);
            chk("out_rd",    XLEN'({io.out_rd_en, io.out_is_load, io.out_rd_index}),
                             XLEN'({m_e.rd_en, m_e.ld, m_e.rd}));
            chk("stall_cnt", XLEN'(stall_cnt), XLEN'(m_stall));
            chk("in_ready",  XLEN'(io.in_ready), XLEN'(rdy));
            chk("rf_ports",  XLEN'({rf_rs1_en, rf_rs2_en, rf_rs1_index, rf_rs2_index}),
                             XLEN'({io.in_rs1_en, io.in_rs2_en, io.in_rs1_index, io.in_rs2_index}));
        end
        if (rst) begin
            m_known = 1;
            m_valid = 0;
            m_e     = '{op: '0, pc: '0, imm: '0, a: '0, b: '0, rd: '0, rd_en: 0, ld: 0};
            m_stall = '0;
        end else if (m_known) begin
            if (io.in_valid && haz && !flush) m_stall = m_stall + 1;
            if (flush) begin
                m_valid = 0;
            end else if (!m_valid || io.out_ready) begin
                m_valid = io.in_valid && rdy;
                if (m_valid) begin
                    m_e.op    = io.in_op;
                    m_e.pc    = io.in_pc;
                    m_e.imm   = io.in_imm;
                    m_e.a     = m_operand(io.in_rs1_en, io.in_rs1_index, rf_rs1_data);
                    m_e.b     = m_operand(io.in_rs2_en, io.in_rs2_index, rf_rs2_data);
                    m_e.rd    = io.in_rd_index;
                    m_e.rd_en = io.in_rd_en;
                    m_e.ld    = io.in_is_load;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        io.in_valid = 0; io.in_op = '0; io.in_pc = '0; io.in_imm = '0;
        io.in_rs1_index = '0; io.in_rs2_index = '0; io.in_rs1_en = 0; io.in_rs2_en = 0;
        io.in_rd_index = '0; io.in_rd_en = 0; io.in_is_load = 0;
        io.out_ready = 1;
        rf_rs1_data = '0; rf_rs2_data = '0;
        fwd_ex_valid = 0; fwd_ex_rd_index = '0; fwd_ex_data = '0; fwd_ex_pending = 0;
        fwd_mem_valid = 0; fwd_mem_rd_index = '0; fwd_mem_data = '0;
        fwd_wb_valid = 0; fwd_wb_rd_index = '0; fwd_wb_data = '0;
        flush = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic rs1_en,
                         input logic [4:0] rd, input logic rd_en);
        io.in_valid = 1; io.in_pc = pc; io.in_op = pc[7:0]; io.in_imm = ~pc;
        io.in_rs1_index = rs1; io.in_rs1_en = rs1_en;
        io.in_rs2_index = '0; io.in_rs2_en = 0;
        io.in_rd_index = rd; io.in_rd_en = rd_en; io.in_is_load = 0;
    endtask

    logic [CNT_W-1:0] s0;
    logic [XLEN-1:0]  pc_hold;

    initial begin
        idle();
        rst = 1;
        cyc(); cyc();
        rst = 0;
        cyc();
        // Reset then idle
        chk("lit_rst_valid", XLEN'(io.out_valid), 0);
        chk("lit_rst_pc",    io.out_pc, 0);
        chk("lit_rst_stall", XLEN'(stall_cnt), 0);
        instr(64'h100, 5'd1, 1, 5'd0, 0); rf_rs1_data = 64'h11;
        cyc();
        chk("lit_add_valid", XLEN'(io.out_valid), 1);
        chk("lit_add_rs1",   io.out_rs1_data, 64'h11);

        // Bypass priority
        instr(64'h104, 5'd5, 1, 5'd0, 0);
        rf_rs1_data = 64'hDD;
        fwd_ex_valid = 1;  fwd_ex_rd_index = 5;  fwd_ex_data = 64'hAA;
        fwd_mem_valid = 1; fwd_mem_rd_index = 5; fwd_mem_data = 64'hBB;
        fwd_wb_valid = 1;  fwd_wb_rd_index = 5;  fwd_wb_data = 64'hCC;
        cyc(); chk("lit_byp_ex", io.out_rs1_data, 64'hAA);
        fwd_ex_valid = 0;
        cyc(); chk("lit_byp_mem", io.out_rs1_data, 64'hBB);
        fwd_mem_valid = 0;
        cyc(); chk("lit_byp_wb", io.out_rs1_data, 64'hCC);
        io.in_rs1_index = 0;
        fwd_ex_valid = 1; fwd_ex_rd_index = 0; fwd_mem_valid = 1; fwd_mem_rd_index = 0;
        fwd_wb_rd_index = 0;
        cyc(); chk("lit_byp_x0", io.out_rs1_data, 64'h0);
        fwd_ex_valid = 0; fwd_mem_valid = 0; fwd_wb_valid = 0;

        // Back-to-back dependency
        instr(64'h200, 5'd0, 0, 5'd3, 1);
        cyc();
        instr(64'h204, 5'd3, 1, 5'd0, 0); rf_rs1_data = 64'h1;
        s0 = stall_cnt;
        #1 chk("lit_dep_block", XLEN'(io.in_ready), 0);
        cyc();
        chk("lit_dep_stall", XLEN'(stall_cnt), XLEN'(s0 + 1));
        fwd_ex_valid = 1; fwd_ex_rd_index = 3; fwd_ex_data = 64'h42;
        #1 chk("lit_dep_ready", XLEN'(io.in_ready), 1);
        cyc();
        chk("lit_dep_data", io.out_rs1_data, 64'h42);

        // Load-use
        instr(64'h300, 5'd7, 1, 5'd0, 0);
        fwd_ex_valid = 1; fwd_ex_rd_index = 7; fwd_ex_pending = 1; fwd_ex_data = 64'hDEAD;
        s0 = stall_cnt;
        #1 chk("lit_ld_block", XLEN'(io.in_ready), 0);
        cyc(); cyc();
        chk("lit_ld_stall", XLEN'(stall_cnt), XLEN'(s0 + 2));
        fwd_ex_pending = 0; fwd_ex_data = 64'h77;
        cyc();
        chk("lit_ld_data", io.out_rs1_data, 64'h77);
        fwd_ex_valid = 0;

        // Backpressure
        io.out_ready = 0;
        pc_hold = io.out_pc;
        instr(64'h400, 5'd0, 0, 5'd0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("lit_bp_ready", XLEN'(io.in_ready), 0);
            cyc();
            chk("lit_bp_pc", io.out_pc, pc_hold);
        end
        io.out_ready = 1;
        #1 chk("lit_bp_release", XLEN'(io.in_ready), 1);
        cyc();
        chk("lit_bp_next", io.out_pc, 64'h400);

        // Flush with an instruction waiting
        instr(64'h500, 5'd0, 0, 5'd0, 0);
        flush = 1;
        s0 = stall_cnt;
        cyc();
        flush = 0; io.in_valid = 0;
        chk("lit_fl_valid", XLEN'(io.out_valid), 0);
        chk("lit_fl_pc",    io.out_pc, 64'h400);
        chk("lit_fl_stall", XLEN'(stall_cnt), XLEN'(s0));

        // Reset while stalled
        instr(64'h600, 5'd0, 0, 5'd9, 1);
        cyc();
        io.out_ready = 0;
        instr(64'h604, 5'd9, 1, 5'd0, 0);
        cyc(); cyc();
        rst = 1;
        cyc();
        rst = 0;
        chk("lit_rst2_valid", XLEN'(io.out_valid), 0);
        chk("lit_rst2_stall", XLEN'(stall_cnt), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            io.in_valid     = ($urandom_range(0, 3) != 0);
            io.in_op        = OP_W'($urandom);
            io.in_pc        = {$urandom, $urandom};
            io.in_imm       = {$urandom, $urandom};
            io.in_rs1_index = 5'($urandom_range(0, 7));
            io.in_rs2_index = 5'($urandom_range(0, 7));
            io.in_rs1_en    = $urandom_range(0, 1);
            io.in_rs2_en    = $urandom_range(0, 1);
            io.in_rd_index  = 5'($urandom_range(0, 7));
            io.in_rd_en     = ($urandom_range(0, 2) == 0);
            io.in_is_load   = $urandom_range(0, 1);
            io.out_ready    = ($urandom_range(0, 3) != 0);
            rf_rs1_data     = {$urandom, $urandom};
            rf_rs2_data     = {$urandom, $urandom};
            fwd_ex_valid    = $urandom_range(0, 1);
            fwd_ex_rd_index = 5'($urandom_range(0, 7));
            fwd_ex_data     = {$urandom, $urandom};
            fwd_ex_pending  = ($urandom_range(0, 7) == 0);
            fwd_mem_valid   = $urandom_range(0, 1);
            fwd_mem_rd_index = 5'($urandom_range(0, 7));
            fwd_mem_data    = {$urandom, $urandom};
            fwd_wb_valid    = $urandom_range(0, 1);
            fwd_wb_rd_index = 5'($urandom_range(0, 7));
            fwd_wb_data     = {$urandom, $urandom};
            flush           = ($urandom_range(0, 15) == 0);
            rst             = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 0;
        idle();
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Operand-fetch / issue stage between decode and execute in the 64-bit RV core.
- Drives the register file's read ports and bypasses results from EX, MEM and WB.
- Detects read-after-write hazards and holds decode until they clear.
- Registers the resolved operands into a valid/ready pipeline register feeding EX.

Parameters:
- XLEN, 64, data width of register values, PC and immediate.
- OP_W, 8, width of the opaque decoded-op bundle passed through to EX.
- CNT_W, 32, width of the hazard-stall performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  decode holds an instruction.
- in_ready  out  1  this stage accepts the instruction this cycle.
- in_op  in  OP_W  decoded op bundle.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  sign-extended immediate.
- in_rs1_index, in_rs2_index  in  5  source register indices.
- in_rs1_en, in_rs2_en  in  1  source is used.
- in_rd_index  in  5  destination index.
- in_rd_en  in  1  instruction writes rd.
- in_is_load  in  1  instruction is a load.
- rf_rs1_index, rf_rs2_index  out  5  register-file read indices; equal to in_rs*_index.
- rf_rs1_en, rf_rs2_en  out  1  register-file read enables; equal to in_rs*_en.
- rf_rs1_data, rf_rs2_data  in  XLEN  combinational register-file read data. This data returns the pre-write value during a WB write.
- fwd_ex_valid, fwd_ex_rd_index, fwd_ex_data, fwd_ex_pending  in  1/5/XLEN/1  EX result. fwd_ex_pending=1 means the result is not yet available (load).
- fwd_mem_valid, fwd_mem_rd_index, fwd_mem_data  in  1/5/XLEN  MEM result.
- fwd_wb_valid, fwd_wb_rd_index, fwd_wb_data  in  1/5/XLEN  WB result, written to the register file at this clock edge.
- flush  in  1  kill the EX-bound register and refuse input this cycle.
- out_valid  out  1  EX-bound register is occupied.
- out_ready  in  1  EX consumes the register this cycle.
- out_op, out_pc, out_imm, out_rs1_data, out_rs2_data, out_rd_index, out_rd_en, out_is_load  out  OP_W/XLEN/XLEN/XLEN/XLEN/5/1/1  registered payload.
- stall_cnt  out  CNT_W  count of hazard-stall cycles.

Behaviour:
- Reset: out_valid=0, every out_* payload field=0, stall_cnt=0. Reset dominates flush and all handshakes.
- Operand resolution (combinational, per source s in {rs1, rs2}):
  - If en=0 or index=0, the value is 0.
  - Otherwise the first match in this priority order supplies the value:
    - EX: fwd_ex_valid && fwd_ex_rd_index==idx && !fwd_ex_pending.
    - MEM.
    - WB.
    - rf_rs*_data.
  - A forwarding source with rd_index=0 never matches.
- Hazard: hazard=1 if any enabled, nonzero source s satisfies either:
  - (a) out_valid && out_rd_en && out_rd_index==s, even when out_ready=1 this cycle, because that result is not yet produced; or
  - (b) fwd_ex_valid && fwd_ex_pending && fwd_ex_rd_index==s.
- in_ready = !flush && !hazard && (!out_valid || out_ready). This is a combinational function of the current inputs and state.
- Register update, evaluated at each posedge in this order:
  - If flush: out_valid<=0; payload held.
  - Else if !out_valid || out_ready:
    - out_valid <= in_valid && in_ready.
    - When in_valid && in_ready, all payload fields latch from in_* and the resolved operands.
    - Otherwise the payload holds.
  - Else (out_valid && !out_ready): hold everything.
- Latency: an instruction accepted at edge N is presented at out_* from cycle N+1. Throughput is one per cycle with no hazards.
- stall_cnt increments by 1 on every cycle with in_valid && hazard && !flush. It wraps modulo 2^CNT_W and is cleared only by rst.
- Simultaneous events:
  - flush with in_valid: the instruction is not accepted.
  - flush with out_ready: the entry is dropped.
  - EX/MEM/WB all matching the same index: the EX value wins.
- No combinational path from out_ready to out_* data. The out_ready-to-in_ready path is permitted.

Test Plan:
- Reset then idle: out_valid=0, payload=0, stall_cnt=0. Issue ADD rs1=x1 with rf_rs1_data=0x11 and no forwarding -> next cycle out_valid=1, out_rs1_data=0x11.
- Bypass priority: rs1=x5; fwd_ex=(x5,0xAA), fwd_mem=(x5,0xBB), fwd_wb=(x5,0xCC), rf=0xDD -> out_rs1_data=0xAA. Drop EX -> 0xBB. Drop MEM -> 0xCC. rs1=x0 with all sources matching x0 -> 0.
- Back-to-back dependency: instr A writes x3 and is issued; instr B reads x3 the next cycle -> in_ready=0 for 1 cycle, stall_cnt=1. The following cycle fwd_ex=(x3,0x42) -> B issues with out_rs1_data=0x42.
- Load-use: fwd_ex_pending=1 on x7 for 2 cycles and B reads x7 -> in_ready=0 for 2 cycles, stall_cnt+=2. Pending clears with data 0x77 -> out_rs1_data=0x77.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable and in_ready=0. out_ready=1 -> the next instruction accepted the same cycle.
- Flush: out_valid=1, flush=1, in_valid=1 -> next cycle out_valid=0, instruction not accepted, stall_cnt unchanged. rst asserted while stalled -> out_valid=0, stall_cnt=0.
